// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// master drives run request and divisor loads; slave is the divider.
interface clk_div_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             out_clk;
  logic             tick;
  logic             running;
  logic             upd_pend;
  logic             cfg_err;

  modport master (
    output en,
    output div_in,
    output div_load,
    input  out_clk,
    input  tick,
    input  running,
    input  upd_pend,
    input  cfg_err
  );

  modport slave (
    input  en,
    input  div_in,
    input  div_load,
    output out_clk,
    output tick,
    output running,
    output upd_pend,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider, any integer N >= 2.
// Ratio changes and start/stop take effect only at period boundaries.
module clk_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_prog_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             upd_pend_q, upd_pend_d;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             p_q, p_d;
  logic             n_q;

  logic             bnd;
  logic             go;
  logic             ld_ok;
  logic [CNT_W:0]   half;

  always_comb begin
    bnd        = (cnt_q == div_act_q - ONE);
    go         = bnd & bus.en;
    ld_ok      = bus.div_load & (bus.div_in >= TWO);
    err_d      = bus.div_load & (bus.div_in < TWO);
    div_act_d  = div_act_q;
    if (go && upd_pend_q) begin
      div_act_d = div_pend_q;
    end
    cnt_d = cnt_q + ONE;
    if (bnd) begin
      cnt_d = bus.en ? '0 : cnt_q;
    end
    run_d      = ~bnd | bus.en;
    tick_d     = go;
    // Extra bit keeps (N+1)>>1 exact when N is the all-ones max.
    half       = ({1'b0, div_act_d} + 1'b1) >> 1;
    p_d        = run_d & ({1'b0, cnt_d} < half);
    div_pend_d = ld_ok ? bus.div_in : div_pend_q;
    upd_pend_d = ld_ok | (upd_pend_q & ~go);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= DEF - ONE;
      div_act_q  <= DEF;
      div_pend_q <= DEF;
      upd_pend_q <= 1'b0;
      run_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      p_q        <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      upd_pend_q <= upd_pend_d;
      run_q      <= run_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      p_q        <= p_d;
    end
  end

  // Half-cycle delayed phase trims the high time for odd ratios.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  assign bus.out_clk  = div_act_q[0] ? (p_q & n_q) : p_q;
  assign bus.tick     = tick_q;
  assign bus.running  = run_q;
  assign bus.upd_pend = upd_pend_q;
  assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog against a period-position model.
// Checks out_clk on both clock phases plus all status outputs.
module tb_clk_div_prog;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

  clk_div_prog #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int m_n, m_pend, m_pos;
  bit m_pv, m_run, m_tick, m_err;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_out(input bit negph);
    int hi;
    if (!m_run) return 1'b0;
    if (m_n % 2 == 0) return m_pos < m_n / 2;
    hi = (m_n - 1) / 2;
    if (negph) return m_pos <= hi;
    return (m_pos >= 1) && (m_pos <= hi);
  endfunction

  task automatic m_reset();
    m_n    = DEF_DIV;
    m_pend = 0;
    m_pv   = 1'b0;
    m_run  = 1'b0;
    m_pos  = 0;
    m_tick = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic m_step(input bit en, input bit ld, input int din);
    if (!m_run || m_pos == m_n - 1) begin
      if (en) begin
        if (m_pv) begin
          m_n  = m_pend;
          m_pv = 1'b0;
        end
        m_pos  = 0;
        m_run  = 1'b1;
        m_tick = 1'b1;
      end else begin
        m_run  = 1'b0;
        m_tick = 1'b0;
      end
    end else begin
      m_pos++;
      m_tick = 1'b0;
    end
    m_err = ld && (din < 2);
    if (ld && din >= 2) begin
      m_pend = din;
      m_pv   = 1'b1;
    end
  endtask

  task automatic cyc(input bit en, input bit ld, input int din);
    bus.en       = en;
    bus.div_load = ld;
    bus.div_in   = din[CNT_W-1:0];
    @(posedge clk);
    m_step(en, ld, din);
    #2;
    expect_eq("tick", {31'b0, bus.tick}, {31'b0, m_tick});
    expect_eq("running", {31'b0, bus.running}, {31'b0, m_run});
    expect_eq("upd_pend", {31'b0, bus.upd_pend}, {31'b0, m_pv});
    expect_eq("cfg_err", {31'b0, bus.cfg_err}, {31'b0, m_err});
    expect_eq("out_clk_pos", {31'b0, bus.out_clk},
              {31'b0, m_out(1'b0)});
    @(negedge clk);
    #2;
    expect_eq("out_clk_neg", {31'b0, bus.out_clk},
              {31'b0, m_out(1'b1)});
  endtask

  task automatic run(input int k, input bit en);
    for (int i = 0; i < k; i++) cyc(en, 1'b0, 0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 600 && !(m_run && m_pos == pos); i++)
      cyc(1'b1, 1'b0, 0);
  endtask

  task automatic chk_idle(input string tag);
    expect_eq({tag, "_out"}, {31'b0, bus.out_clk}, 32'd0);
    expect_eq({tag, "_tick"}, {31'b0, bus.tick}, 32'd0);
    expect_eq({tag, "_run"}, {31'b0, bus.running}, 32'd0);
    expect_eq({tag, "_upd"}, {31'b0, bus.upd_pend}, 32'd0);
    expect_eq({tag, "_err"}, {31'b0, bus.cfg_err}, 32'd0);
  endtask

  initial begin
    int r, din;
    bit en, ld;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    m_reset();
    #12;
    chk_idle("reset");
    rst_n = 1'b1;

    run(16, 1'b1);

    cyc(1'b1, 1'b1, 0);
    cyc(1'b1, 1'b1, 1);
    run(8, 1'b1);

    run_to(1);
    cyc(1'b1, 1'b1, 3);
    run(14, 1'b1);

    cyc(1'b1, 1'b1, 6);
    for (int i = 0; i < 20 && m_n != 6; i++) cyc(1'b1, 1'b0, 0);
    run_to(1);
    run(12, 1'b0);
    run(14, 1'b1);

    run_to(0);
    cyc(1'b1, 1'b1, 7);
    run_to(m_n - 1);
    cyc(1'b1, 1'b1, 5);
    run(24, 1'b1);

    cyc(1'b1, 1'b1, 255);
    run(600, 1'b1);
    run_to(10);
    cyc(1'b1, 1'b1, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    m_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    run(12, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      en  = (r < 90);
      ld  = ($urandom_range(0, 15) == 0);
      r   = int'($urandom_range(0, 19));
      if (r < 3)       din = int'($urandom_range(0, 1));
      else if (r < 18) din = int'($urandom_range(2, 11));
      else             din = int'($urandom_range(200, 255));
      cyc(en, ld, din);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable clock divider generating a 50 %-duty `out_clk` for any integer ratio N ≥ 2, odd or even, from one source clock. Successor to the fixed even-ratio divider: the ratio is runtime-loadable, a new ratio takes effect only at a period boundary, and start/stop never produces a runt pulse. Feeds slow peripheral clocks and periodic enable ticks in the fabric.

## Interface
- `CNT_W`, 8: width of divisor and counter; max N = 2^CNT_W − 1.
- `DEF_DIV`, 4: divisor after reset; must be ≥ 2 and < 2^CNT_W.
- `clk`  in  1  source clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request, sampled only at period boundary.
- `div_in`  in  CNT_W  new divisor value.
- `div_load`  in  1  one-cycle strobe, captures `div_in`.
- `out_clk`  out  1  divided clock, 50 % duty (N/2 source cycles high).
- `tick`  out  1  one-`clk`-cycle pulse at the start of each output period.
- `running`  out  1  divider is producing periods.
- `upd_pend`  out  1  loaded divisor waiting for next boundary.
- `cfg_err`  out  1  one-cycle pulse: rejected load (`div_in` < 2).

## Operation
- State: `cnt` (CNT_W), `div_act`, `div_pend`, `upd_pend`, posedge phase reg `p`, negedge reg `n`.
- Reset (async): `cnt` = DEF_DIV−1, `div_act` = DEF_DIV, `p` = `n` = 0, `upd_pend` = 0; all outputs 0.
- States: PARKED (`cnt` = N−1, `p` = 0, `running` = 0) and RUN.
- Boundary = posedge where `cnt` = N−1. At a boundary: if `en` = 1, `cnt` → 0, `running` = 1, and if `upd_pend` then `div_act` ← `div_pend`, `upd_pend` ← 0. If `en` = 0, hold `cnt` = N−1, `running` = 0 (PARKED).
- Otherwise in RUN: `cnt` ← `cnt`+1; `en` is ignored mid-period, so the current period always completes.
- `p` ← (next `cnt` < ⌈N/2⌉) in RUN, 0 in PARKED, where N = value of `div_act` after the update. Compare in CNT_W+1 bits: ⌈N/2⌉ = (N+1)>>1.
- `n` ← `p` on negedge `clk`.
- `out_clk` = `p` if `div_act` even, `p & n` if odd. It has no other logic and stays glitch-free.
- `tick` ← 1 at the posedge where `cnt` becomes 0, else 0.
- Load: `div_load` with `div_in` ≥ 2 sets `div_pend` ← `div_in`, `upd_pend` ← 1. A later load overwrites the pending value.
- Load with `div_in` < 2: `cfg_err` pulses for one cycle. `div_pend` and `upd_pend` are unchanged.
- Load on the same cycle as a boundary: the boundary applies the previously pending value (if any). The new value becomes pending for the following boundary.
- Load while PARKED is applied at restart.

## Timing
- From reset release with `en` = 1: first posedge is a boundary. `out_clk`, `tick` and `running` assert from that edge (even N). For odd N, `out_clk` rises at the following negedge.
- Even N: high N/2 cycles, low N/2, rising edge at posedge.
- Odd N: rises at negedge, falls at posedge. High (N−1)/2 + ½ cycles, low the same.
- `tick` is high for exactly one `clk` cycle per period, aligned to `cnt` = 0.
- Divisor change latency: first period using the new N begins at the first boundary strictly after the load cycle. `upd_pend` drops at that edge.
- Stop latency: after `en` = 0, at most N−1 further cycles, then PARKED with `out_clk` = 0.
- Restart: `en` = 1 while PARKED starts a period at the next posedge.
- Reset mid-period: `out_clk`, `tick`, `running`, `cfg_err`, `upd_pend` go to 0 immediately, without waiting for an edge.

## Test plan
- Reset, DEF_DIV = 4, `en` = 1 → `out_clk` period 4 cycles, 2 high; `tick` every 4th cycle; `running` = 1 from first edge.
- Load 3 at `cnt` = 1 → `upd_pend` = 1 until next boundary. Then period 3, `out_clk` high 1.5 cycles, rising on negedge.
- Load 0, then 1 → two `cfg_err` pulses; divisor stays 4; `upd_pend` stays 0.
- `en` dropped at `cnt` = 1, N = 6 → period completes; PARKED after 4 more edges with `out_clk` = 0. Re-raise `en` → `tick` at next posedge.
- Load 5 on a boundary cycle while 7 is pending → that period uses 7, the next uses 5.
- CNT_W = 8, load 255 → high 127.5 cycles, low 127.5. Async reset mid-high → `out_clk` = 0 before the next edge.
